// File: rtl/sys_cfg_regfile_if.sv
// Config-bus interface between the AXI BRAM controller port (master) and the
// sys_cfg_regfile register block (slave).
//
// Bus semantics: there is no ready; the slave accepts every cycle in which
// bram_en=1. bram_we!=0 marks a write (byte lanes chosen by bram_we) that
// takes effect at the next clock edge. bram_we==0 marks a read whose data
// appears on bram_dout one cycle later. bram_dout holds its value otherwise.
interface sys_cfg_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4
);
    logic                  bram_en;
    logic [BYTE_NUM-1:0]   bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport master (
        output bram_en, bram_we, bram_addr, bram_din,
        input  bram_dout
    );

    modport slave (
        input  bram_en, bram_we, bram_addr, bram_din,
        output bram_dout
    );
endinterface

// File: rtl/sys_cfg_regfile.sv
// Parametrised system config register file on the PS-PL config bus.
// REG_NUM byte-writable RW registers, STS_NUM sticky W1C status registers,
// a CTRL word (self-clearing start pulse, optional commit) and a saturating
// error counter for out-of-range accesses.
// Optional feature macro: SYS_CFG_SHADOW_EN (shadowed cfg_regs with commit).
module sys_cfg_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_NUM   = 4,
    parameter int                    REG_NUM    = 16,
    parameter int                    STS_NUM    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                          clk,
    input  logic                          rstn,
    sys_cfg_regfile_if.slave              bus,
    output logic [REG_NUM*DATA_WIDTH-1:0] cfg_regs,
    output logic [REG_NUM-1:0]            cfg_wr_strb,
    input  logic [STS_NUM*DATA_WIDTH-1:0] sts_set,
    output logic                          cfg_start
);
    localparam int                    LG       = $clog2(BYTE_NUM);
    localparam logic [ADDR_WIDTH-1:0] STS_LO   = ADDR_WIDTH'(REG_NUM);
    localparam logic [ADDR_WIDTH-1:0] CTRL_IDX = ADDR_WIDTH'(REG_NUM + STS_NUM);
    localparam logic [ADDR_WIDTH-1:0] ERR_IDX  = ADDR_WIDTH'(REG_NUM + STS_NUM + 1);

    logic                  below_base;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  hit_rw, hit_sts, hit_ctrl, hit_err, hit_oor;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] work_q [REG_NUM];
    logic [DATA_WIDTH-1:0] sts_q  [STS_NUM];
    logic [15:0]           err_cnt_q;

    // Word decode; sub-word address bits are dropped by the shift.
    assign below_base = bus.bram_addr < BASE_ADDR;
    assign word_idx   = (bus.bram_addr - BASE_ADDR) >> LG;
    assign hit_rw     = !below_base && (word_idx < STS_LO);
    assign hit_sts    = !below_base && (word_idx >= STS_LO) && (word_idx < CTRL_IDX);
    assign hit_ctrl   = !below_base && (word_idx == CTRL_IDX);
    assign hit_err    = !below_base && (word_idx == ERR_IDX);
    assign hit_oor    = !(hit_rw || hit_sts || hit_ctrl || hit_err);
    assign wr_en      = bus.bram_en && (bus.bram_we != '0);
    assign rd_en      = bus.bram_en && (bus.bram_we == '0);

    // Expand byte enables into a per-bit write mask.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BYTE_NUM; b++) begin
            lane_mask[b*8 +: 8] = {8{bus.bram_we[b]}};
        end
    end

    // Working registers: byte-lane merge on a matching write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REG_NUM; i++) work_q[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_en && hit_rw && word_idx == ADDR_WIDTH'(i)) begin
                    work_q[i] <= (work_q[i] & ~lane_mask) | (bus.bram_din & lane_mask);
                end
            end
        end
    end

    // Sticky status: set bits win over a same-cycle W1C of the same bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < STS_NUM; j++) sts_q[j] <= '0;
        end else begin
            for (int j = 0; j < STS_NUM; j++) begin
                if (wr_en && hit_sts && word_idx == STS_LO + ADDR_WIDTH'(j)) begin
                    sts_q[j] <= (sts_q[j] & ~(bus.bram_din & lane_mask))
                                | sts_set[j*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    sts_q[j] <= sts_q[j] | sts_set[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Error counter: cleared by any write, bumped by out-of-range accesses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else if (wr_en && hit_err) begin
            err_cnt_q <= '0;
        end else if (bus.bram_en && hit_oor && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    // Read mux; CTRL and out-of-range words read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (hit_rw && word_idx == ADDR_WIDTH'(i)) rd_word = work_q[i];
        end
        for (int j = 0; j < STS_NUM; j++) begin
            if (hit_sts && word_idx == STS_LO + ADDR_WIDTH'(j)) rd_word = sts_q[j];
        end
        if (hit_err) rd_word = DATA_WIDTH'(err_cnt_q);
    end

    // Registered read data, held on idle and write cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      bus.bram_dout <= '0;
        else if (rd_en) bus.bram_dout <= rd_word;
    end

    // Soft-start pulse from CTRL bit0 in byte lane 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cfg_start <= 1'b0;
        else       cfg_start <= wr_en && hit_ctrl && bus.bram_we[0] && bus.bram_din[0];
    end

`ifdef SYS_CFG_SHADOW_EN
    logic                  commit;
    logic [DATA_WIDTH-1:0] shadow_q [REG_NUM];

    assign commit = wr_en && hit_ctrl && bus.bram_we[0] && bus.bram_din[1];

    // Shadow copy captures all working registers on a commit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REG_NUM; i++) shadow_q[i] <= RST_VAL;
        end else if (commit) begin
            for (int i = 0; i < REG_NUM; i++) shadow_q[i] <= work_q[i];
        end
    end

    // Every strobe fires together in the cycle the shadow updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cfg_wr_strb <= '0;
        else       cfg_wr_strb <= {REG_NUM{commit}};
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_cfg_out
        assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = shadow_q[g];
    end
`else
    // One strobe bit per written register, for the cycle after the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_wr_strb <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                cfg_wr_strb[i] <= wr_en && hit_rw && word_idx == ADDR_WIDTH'(i);
            end
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_cfg_out
        assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = work_q[g];
    end
`endif

endmodule

// File: doc/sys_cfg_regfile.md
Name: sys_cfg_regfile

Overview:
- Parametrised successor to the fixed four-register system config block.
- Slave of the AXI BRAM controller port on the PS-PL config bus.
- Provides REG_NUM read/write config registers with byte-lane writes and STS_NUM sticky write-1-to-clear status registers.
- Adds a control word with a self-clearing start pulse and per-register write strobes, so downstream logic can react to config updates.

Parameters:
- ADDR_WIDTH, 32, bram_addr width (byte address).
- DATA_WIDTH, 32, register/data width; must equal 8*BYTE_NUM.
- BYTE_NUM, 4, byte lanes per word (bram_we width).
- REG_NUM, 16, number of RW config registers (1..64).
- STS_NUM, 4, number of sticky status registers (1..16).
- BASE_ADDR, 32'h0, byte base address of the block.
- RST_VAL, 0, reset value of every RW register (DATA_WIDTH bits).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- bram_en  in  1  access enable
- bram_we  in  BYTE_NUM  byte write enables; all zero = read
- bram_addr  in  ADDR_WIDTH  byte address
- bram_din  in  DATA_WIDTH  write data
- bram_dout  out  DATA_WIDTH  registered read data
- cfg_regs  out  REG_NUM*DATA_WIDTH  flattened RW registers; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- cfg_wr_strb  out  REG_NUM  one-cycle pulse per RW register written
- sts_set  in  STS_NUM*DATA_WIDTH  flattened status set bits; level-sampled every cycle
- cfg_start  out  1  one-cycle soft-start pulse

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous assert, synchronous deassert (synchroniser external), active-low.
- Reset values:
  - cfg_regs = RST_VAL for every register.
  - Status registers = 0.
  - bram_dout = 0.
  - cfg_wr_strb = 0; cfg_start = 0.
- Address decode: idx = (bram_addr - BASE_ADDR) >> log2(BYTE_NUM). Low address bits are ignored (no misalignment error).
  - idx 0..REG_NUM-1: RW register.
  - idx REG_NUM..REG_NUM+STS_NUM-1: status register.
  - idx REG_NUM+STS_NUM: CTRL.
  - idx REG_NUM+STS_NUM+1: ERR_CNT.
  - Anything else, or bram_addr < BASE_ADDR: out of range.
- Write (bram_en=1, bram_we!=0), effective at the next edge:
  - RW register: only lanes with we[b]=1 updated. cfg_wr_strb[idx]=1 for exactly the following cycle.
  - Status register: W1C per bit, masked by byte lane.
  - CTRL: bit0=1 with we[0] drives cfg_start=1 for one cycle; CTRL stores nothing. bit1 is COMMIT (see Optional Feature).
  - ERR_CNT: any write clears it to 0.
  - Out of range: no register changes; ERR_CNT increments, saturating at 2^16-1.
- Read (bram_en=1, bram_we=0): bram_dout = selected word one cycle later (latency 1, matches the BRAM controller read latency setting of 1).
  - CTRL reads 0.
  - ERR_CNT reads {zero-pad, cnt[15:0]}.
  - Out of range reads 0 and also increments ERR_CNT.
  - bram_dout holds its value when bram_en=0 or on write cycles.
- Status registers: sts_q <= (sts_q & ~w1c_mask) | sts_set every cycle. Set wins over a same-cycle clear of the same bit.
- Read-after-write to the same address on consecutive cycles returns the new value.
- Back-to-back writes to the same RW register: each write produces its own strobe, so strobes may stay high on consecutive cycles.
- Reset mid-access: every output returns to its reset value immediately. A pending strobe or pulse is dropped.

Optional Feature:
- Macro SYS_CFG_SHADOW_EN.
- When defined:
  - cfg_regs is driven from a shadow copy, loaded from the working registers only in the cycle after a CTRL write with bit1=1 and we[0]=1.
  - Reads return the working registers.
  - The shadow reset value is RST_VAL.
  - cfg_wr_strb fires only on commit, for all registers at once.
- When not defined: cfg_regs = working registers directly; CTRL bit1 is ignored.

Test Plan:
- Reset, then read every idx (default REG_NUM=16, STS_NUM=4) -> RW=RST_VAL, status=0, CTRL=0, ERR_CNT=0; dout valid exactly 1 cycle after bram_en.
- Write 0xA5A5A5A5 to idx 3, then we=4'b0010 with din 0x0000FF00 -> read idx 3 = 0xA5A5FFA5; cfg_wr_strb[3] high 1 cycle after each write, all other strobe bits 0.
- sts_set bit 5 of status 0 pulsed 1 cycle, then W1C 0x20 to idx 16 -> reads 0x20, then 0. Repeat with sts_set held high during the W1C -> stays 0x20.
- Write CTRL (idx 20) = 0x1 -> cfg_start high exactly 1 cycle; CTRL readback 0.
- Read addr 0x100 and write addr 0x104 -> reads 0, no RW register changes, ERR_CNT=2. Write ERR_CNT -> 0. Force 65536 errors -> ERR_CNT saturates at 0xFFFF.
- SYS_CFG_SHADOW_EN: write idx 0 = 0x12345678 -> cfg_regs[0] unchanged, no strobe. Write CTRL=0x2 -> cfg_regs[0]=0x12345678 and all strobes high 1 cycle. Assert rstn low mid-commit -> all outputs return to reset values.
